// File: rtl/inst_decode_stage.sv
// Decode stage: RV64IM+Zicsr instruction decode with a registered output
// and a two-entry skid buffer between fetch and execute.

package corectrl_pkg;
  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    INST_X = 3'd0,
    INST_R = 3'd1,
    INST_I = 3'd2,
    INST_S = 3'd3,
    INST_B = 3'd4,
    INST_U = 3'd5,
    INST_J = 3'd6
  } inst_type_e;

  // 24-bit decoded control word; rsvd keeps the layout at its fixed width
  typedef struct packed {
    inst_type_e  itype;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        rwb_en;
    logic        is_aluop;
    logic        is_muldiv;
    logic        is_op32;
    logic        is_lui;
    logic        is_jump;
    logic        is_load;
    logic        is_csr;
    logic [2:0]  rsvd;
  } inst_ctrl_t;

  localparam logic [3:0] ILLEGAL_INSTRUCTION = 4'd2;

  typedef struct packed {
    logic            valid;
    logic [3:0]      cause;
    logic [XLEN-1:0] value;
  } exc_info_t;
endpackage

module inst_decode_stage
  import corectrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_addr,
  input  logic [ILEN-1:0] if_bits,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_addr,
  output logic [ILEN-1:0] id_bits,
  output inst_ctrl_t      id_ctrl,
  output logic [XLEN-1:0] id_imm,
  output exc_info_t       id_exc
);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] bits;
    inst_ctrl_t      ctrl;
    logic [XLEN-1:0] imm;
    exc_info_t       exc;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d, new_ent;
  logic   m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic   acc, dlv, ill;

  // Combinational decode of the word presented by fetch
  always_comb begin
    new_ent             = '0;
    ill                 = 1'b0;
    new_ent.addr        = if_addr;
    new_ent.bits        = if_bits;
    new_ent.ctrl.itype  = INST_X;
    new_ent.ctrl.funct3 = if_bits[14:12];
    new_ent.ctrl.funct7 = if_bits[31:25];
    case (if_bits[6:0])
      7'b0110011: begin
        new_ent.ctrl.itype     = INST_R;
        new_ent.ctrl.rwb_en    = 1'b1;
        new_ent.ctrl.is_aluop  = 1'b1;
        new_ent.ctrl.is_muldiv = (if_bits[31:25] == 7'b0000001);
      end
      7'b0111011: begin
        new_ent.ctrl.itype     = INST_R;
        new_ent.ctrl.rwb_en    = 1'b1;
        new_ent.ctrl.is_aluop  = 1'b1;
        new_ent.ctrl.is_op32   = 1'b1;
        new_ent.ctrl.is_muldiv = (if_bits[31:25] == 7'b0000001);
      end
      7'b0010011: begin
        new_ent.ctrl.itype    = INST_I;
        new_ent.ctrl.rwb_en   = 1'b1;
        new_ent.ctrl.is_aluop = 1'b1;
      end
      7'b0011011: begin
        new_ent.ctrl.itype    = INST_I;
        new_ent.ctrl.rwb_en   = 1'b1;
        new_ent.ctrl.is_aluop = 1'b1;
        new_ent.ctrl.is_op32  = 1'b1;
      end
      7'b0110111: begin
        new_ent.ctrl.itype  = INST_U;
        new_ent.ctrl.rwb_en = 1'b1;
        new_ent.ctrl.is_lui = 1'b1;
      end
      7'b0010111: begin
        new_ent.ctrl.itype  = INST_U;
        new_ent.ctrl.rwb_en = 1'b1;
      end
      7'b1101111: begin
        new_ent.ctrl.itype   = INST_J;
        new_ent.ctrl.rwb_en  = 1'b1;
        new_ent.ctrl.is_jump = 1'b1;
      end
      7'b1100111: begin
        new_ent.ctrl.itype   = INST_I;
        new_ent.ctrl.rwb_en  = 1'b1;
        new_ent.ctrl.is_jump = 1'b1;
      end
      7'b1100011: new_ent.ctrl.itype = INST_B;
      7'b0000011: begin
        new_ent.ctrl.itype   = INST_I;
        new_ent.ctrl.rwb_en  = 1'b1;
        new_ent.ctrl.is_load = 1'b1;
      end
      7'b0100011: new_ent.ctrl.itype = INST_S;
      7'b1110011: begin
        new_ent.ctrl.itype  = INST_I;
        new_ent.ctrl.is_csr = 1'b1;
        new_ent.ctrl.rwb_en = (if_bits[14:12] != 3'b000);
      end
      // fence family decodes as a plain I-type with no side effects
      7'b0001111: new_ent.ctrl.itype = INST_I;
      // every legal opcode ends in 2'b11, so compressed/garbage words land here
      default:    ill = 1'b1;
    endcase

    case (new_ent.ctrl.itype)
      INST_I:  new_ent.imm = {{(XLEN-12){if_bits[31]}}, if_bits[31:20]};
      INST_S:  new_ent.imm = {{(XLEN-12){if_bits[31]}}, if_bits[31:25], if_bits[11:7]};
      INST_B:  new_ent.imm = {{(XLEN-13){if_bits[31]}}, if_bits[31], if_bits[7],
                              if_bits[30:25], if_bits[11:8], 1'b0};
      INST_U:  new_ent.imm = {{(XLEN-32){if_bits[31]}}, if_bits[31:12], 12'b0};
      INST_J:  new_ent.imm = {{(XLEN-21){if_bits[31]}}, if_bits[31], if_bits[19:12],
                              if_bits[20], if_bits[30:21], 1'b0};
      default: new_ent.imm = '0;
    endcase

    if (ill) begin
      new_ent.exc.valid = 1'b1;
      new_ent.exc.cause = ILLEGAL_INSTRUCTION;
      new_ent.exc.value = {{(XLEN-ILEN){1'b0}}, if_bits};
    end
  end

  assign if_ready = !s_vld_q;
  assign acc      = if_valid && if_ready;
  assign dlv      = m_vld_q && id_ready;

  // Skid-buffer next state: M refills from S first to keep FIFO order
  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q || dlv) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else if (acc) begin
        m_d     = new_ent;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (acc) begin
      s_d     = new_ent;
      s_vld_d = 1'b1;
    end
  end

  // State registers; an all-zero entry reads as itype INST_X
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  assign id_valid = m_vld_q;
  assign id_addr  = m_q.addr;
  assign id_bits  = m_q.bits;
  assign id_ctrl  = m_q.ctrl;
  assign id_imm   = m_q.imm;
  assign id_exc   = m_q.exc;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage with hand-computed expectations.
module tb_inst_decode_stage;
  import corectrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready, id_valid, id_ready;
  logic [63:0] if_addr, id_addr, id_imm;
  logic [31:0] if_bits, id_bits;
  inst_ctrl_t  id_ctrl, ec;
  exc_info_t   id_exc;
  int          n_cmp = 0, n_err = 0;

  inst_decode_stage #(.XLEN(64), .ILEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr), .if_bits(if_bits),
    .id_valid(id_valid), .id_ready(id_ready), .id_addr(id_addr), .id_bits(id_bits),
    .id_ctrl(id_ctrl), .id_imm(id_imm), .id_exc(id_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle offer of a word from fetch
  task automatic send(input logic [63:0] a, input logic [31:0] b);
    if_valid = 1'b1; if_addr = a; if_bits = b;
    tick();
    if_valid = 1'b0;
  endtask

  function automatic inst_ctrl_t mk(input inst_type_e t, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [7:0] fl);
    inst_ctrl_t c;
    c = '0;
    c.itype = t; c.funct3 = f3; c.funct7 = f7;
    {c.rwb_en, c.is_aluop, c.is_muldiv, c.is_op32,
     c.is_lui, c.is_jump, c.is_load, c.is_csr} = fl;
    return c;
  endfunction

  // flag order: rwb aluop muldiv op32 lui jump load csr
  task automatic dec(input string tag, input logic [31:0] b, input inst_ctrl_t c,
                     input logic [63:0] imm);
    send(64'h1000, b);
    chk({tag, ".valid"}, id_valid, 1'b1);
    chk({tag, ".ctrl"}, id_ctrl, c);
    chk({tag, ".imm"}, id_imm, imm);
    chk({tag, ".exc"}, id_exc.valid, 1'b0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    if_addr = '0; if_bits = '0;
    tick(); tick();
    chk("rst.id_valid", id_valid, 1'b0);
    chk("rst.if_ready", if_ready, 1'b1);
    chk("rst.itype", id_ctrl.itype, INST_X);
    rst = 1'b1;
    tick();

    // addi x1,x0,5 at 0x80000000
    send(64'h8000_0000, 32'h0050_0093);
    chk("addi.valid", id_valid, 1'b1);
    chk("addi.addr", id_addr, 64'h8000_0000);
    chk("addi.ctrl", id_ctrl, mk(INST_I, 3'b000, 7'h00, 8'b1100_0000));
    chk("addi.imm", id_imm, 64'd5);
    chk("addi.exc", id_exc.valid, 1'b0);

    dec("sw",    32'hFE20_AE23, mk(INST_S, 3'b010, 7'h7F, 8'b0000_0000), 64'hFFFF_FFFF_FFFF_FFFC);
    dec("mul",   32'h0220_81B3, mk(INST_R, 3'b000, 7'h01, 8'b1110_0000), 64'd0);
    dec("divw",  32'h0220_C1BB, mk(INST_R, 3'b100, 7'h01, 8'b1111_0000), 64'd0);
    dec("lui",   32'h1234_5537, mk(INST_U, 3'b101, 7'h09, 8'b1000_1000), 64'h1234_5000);
    dec("jal",   32'h0080_00EF, mk(INST_J, 3'b000, 7'h00, 8'b1000_0100), 64'd8);
    dec("beq",   32'hFE00_0EE3, mk(INST_B, 3'b000, 7'h7F, 8'b0000_0000), 64'hFFFF_FFFF_FFFF_FFFC);
    dec("csrrs", 32'h3000_22F3, mk(INST_I, 3'b010, 7'h18, 8'b1000_0001), 64'h300);
    dec("ecall", 32'h0000_0073, mk(INST_I, 3'b000, 7'h00, 8'b0000_0001), 64'd0);

    // illegal opcodes
    send(64'h2000, 32'h0000_007F);
    chk("ill7f.ctrl", id_ctrl, mk(INST_X, 3'b000, 7'h00, 8'h00));
    chk("ill7f.imm", id_imm, 64'd0);
    chk("ill7f.exc", id_exc, {1'b1, ILLEGAL_INSTRUCTION, 64'h7F});
    send(64'h2004, 32'h0000_0000);
    chk("ill00.valid", id_valid, 1'b1);
    chk("ill00.exc", id_exc, {1'b1, ILLEGAL_INSTRUCTION, 64'h0});
    tick();
    chk("drain.valid", id_valid, 1'b0);

    // backpressure: A, B fill M and S; C waits
    id_ready = 1'b0;
    send(64'hA0, 32'h0010_0093);
    chk("bp.ready_a", if_ready, 1'b1);
    send(64'hB0, 32'h0020_0093);
    chk("bp.ready_b", if_ready, 1'b0);
    chk("bp.hold_a", id_bits, 32'h0010_0093);
    if_valid = 1'b1; if_addr = 64'hC0; if_bits = 32'h0030_0093;
    tick();
    chk("bp.c_held", id_bits, 32'h0010_0093);
    chk("bp.c_held_imm", id_imm, 64'd1);
    id_ready = 1'b1;
    tick();
    chk("bp.out_b", id_bits, 32'h0020_0093);
    chk("bp.ready_after_a", if_ready, 1'b1);
    tick();
    if_valid = 1'b0;
    chk("bp.out_c", id_bits, 32'h0030_0093);
    chk("bp.out_c_addr", id_addr, 64'hC0);
    chk("bp.c_valid", id_valid, 1'b1);
    tick();
    chk("bp.empty", id_valid, 1'b0);

    // flush with M and S full, concurrent offer from fetch
    id_ready = 1'b0;
    send(64'hD0, 32'h0040_0093);
    send(64'hD4, 32'h0050_0093);
    flush = 1'b1; if_valid = 1'b1; if_addr = 64'hD8; if_bits = 32'h0060_0093;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("fl.valid", id_valid, 1'b0);
    chk("fl.ready", if_ready, 1'b1);
    id_ready = 1'b1;
    tick();
    chk("fl.still_empty", id_valid, 1'b0);
    send(64'hE0, 32'h0070_0093);
    chk("fl.next_bits", id_bits, 32'h0070_0093);
    tick();

    // reset mid-stall
    id_ready = 1'b0;
    send(64'hF0, 32'h0080_0093);
    send(64'hF4, 32'h0090_0093);
    chk("rs.full", if_ready, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rs.valid", id_valid, 1'b0);
    chk("rs.ready", if_ready, 1'b1);
    chk("rs.payload", {id_addr, id_bits, id_imm}, '0);
    chk("rs.ctrl", id_ctrl, '0);
    chk("rs.exc", id_exc, '0);
    id_ready = 1'b1;
    send(64'h100, 32'h00A0_0093);
    chk("rs.first", id_bits, 32'h00A0_0093);
    chk("rs.first_imm", id_imm, 64'd10);
    tick();
    chk("rs.done", id_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
